twi_slave: RTL

- Single-clock I2C/TWI target: the responder end of the existing TWI master, for on-chip loopback tests and slave-side peripherals.
- Oversamples SCL/SDA, detects START/STOP, matches a 7-bit device address and accepts a register-pointer byte.
- Converts bus write and read transfers into a simple 8-bit register port with auto-incrementing address.
- SDA is open-drain: the block only ever pulls it low.

---
 rtl/twi_slave.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/twi_slave.sv
// twi_slave: I2C/TWI target with address match, register pointer and an
// auto-incrementing 8-bit register port; SDA is open-drain (pull-low only).
module twi_slave #(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  input  logic [7:0] reg_rdata,
  output logic       busy
);
  typedef enum logic [3:0] {
    S_IDLE, S_DEV_ADDR, S_DEV_ACK, S_REG_ADDR, S_REG_ACK,
    S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
  } state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_prev_q, sda_prev_q;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d, addr_q, addr_d, wdata_q, wdata_d;
  logic rw_q, rw_d, ack_q, ack_d, load_q, load_d;
  logic oe_q, oe_d, busy_q, busy_d, we_q, we_d;
  logic scl_s, sda_s, rise, fall, start, stop, in_byte;
  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];
  assign rise  = scl_s & ~scl_prev_q;
  assign fall  = ~scl_s & scl_prev_q;
  assign start = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign in_byte = state_q inside {S_DEV_ADDR, S_REG_ADDR, S_WR_DATA};
  assign sda_oe    = oe_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign busy      = busy_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'h00;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      rw_q       <= 1'b0;
      ack_q      <= 1'b1;
      load_q     <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      we_q       <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
      load_q     <= load_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      we_q       <= we_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    ack_d   = ack_q;
    load_d  = 1'b0;
    oe_d    = oe_q;
    busy_d  = busy_q;
    we_d    = 1'b0;
    if (start) begin
      state_d = S_DEV_ADDR;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
    end else if (stop) begin
      state_d = S_IDLE;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      // read data for the freshly incremented pointer arrives one clk after the ACK edge
      if (load_q) begin
        shift_d = reg_rdata;
        oe_d    = ~reg_rdata[7];
      end
      if (rise && in_byte && cnt_q != 4'd8) begin
        shift_d = {shift_q[6:0], sda_s};
        cnt_d   = cnt_q + 4'd1;
        if (state_q == S_WR_DATA && cnt_q == 4'd7) begin
          we_d    = 1'b1;
          wdata_d = {shift_q[6:0], sda_s};
        end
      end
      case (state_q)
        S_DEV_ADDR: if (fall && cnt_q == 4'd8) begin
          cnt_d = 4'd0;
          if (shift_q[7:1] == DEV_ADDR) begin
            oe_d    = 1'b1;
            busy_d  = 1'b1;
            rw_d    = shift_q[0];
            state_d = S_DEV_ACK;
          end else begin
            busy_d  = 1'b0;
            state_d = S_IGNORE;
          end
        end
        S_DEV_ACK: if (fall) begin
          cnt_d   = 4'd0;
          shift_d = reg_rdata;
          oe_d    = rw_q ? ~reg_rdata[7] : 1'b0;
          state_d = rw_q ? S_RD_DATA : S_REG_ADDR;
        end
        S_REG_ADDR: if (fall && cnt_q == 4'd8) begin
          cnt_d   = 4'd0;
          addr_d  = shift_q;
          oe_d    = 1'b1;
          state_d = S_REG_ACK;
        end
        S_REG_ACK: if (fall) begin
          oe_d    = 1'b0;
          state_d = S_WR_DATA;
        end
        S_WR_DATA: if (fall && cnt_q == 4'd8) begin
          cnt_d   = 4'd0;
          oe_d    = 1'b1;
          state_d = S_WR_ACK;
        end
        S_WR_ACK: if (fall) begin
          oe_d    = 1'b0;
          addr_d  = addr_q + 8'd1;
          state_d = S_WR_DATA;
        end
        S_RD_DATA: if (fall) begin
          cnt_d   = cnt_q == 4'd7 ? 4'd0 : cnt_q + 4'd1;
          shift_d = {shift_q[6:0], 1'b0};
          oe_d    = cnt_q == 4'd7 ? 1'b0 : ~shift_q[6];
          state_d = cnt_q == 4'd7 ? S_RD_ACK : S_RD_DATA;
        end
        S_RD_ACK: begin
          if (rise) ack_d = sda_s;
          if (fall) begin
            cnt_d   = 4'd0;
            addr_d  = ack_q ? addr_q : addr_q + 8'd1;
            load_d  = ~ack_q;
            state_d = ack_q ? S_IGNORE : S_RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
